mux_sel_pipe: RTL

MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

---
 rtl/mux_sel_pipe_if.sv | 27 ++
 rtl/mux_sel_pipe.sv | 101 ++++++++++
 2 files changed

// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: producer/consumer bundle for mux_sel_pipe.
// master = the side that offers select/data beats and consumes Mux_Out;
// slave  = the mux pipeline itself.
interface mux_sel_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        Ctrl;
  logic [NUM_IN*WIDTH-1:0] Entradas;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        Mux_Out;
  logic                    sel_err;

  modport master (
    output in_valid, Ctrl, Entradas, out_ready,
    input  in_ready, out_valid, Mux_Out, sel_err
  );

  modport slave (
    input  in_valid, Ctrl, Entradas, out_ready,
    output in_ready, out_valid, Mux_Out, sel_err
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N:1 channel select feeding a 2-entry output FIFO.
// An out-of-range Ctrl yields a zero data beat tagged with sel_err.
// Optional feature macro: MUX_SEL_ERR_CNT_EN adds err_cnt[7:0], a saturating
// count of captured out-of-range beats.
module mux_sel_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  mux_sel_pipe_if.slave    bus
`ifdef MUX_SEL_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  logic [1:0]       count;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] tail_data;
  logic             head_err;
  logic             tail_err;
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             push;
  logic             pop;

  // Flow control depends only on the registered occupancy.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Outputs come straight from the head register.
  assign bus.Mux_Out = head_data;
  assign bus.sel_err = head_err;

  // Channel select; leaves zero data and sel_hit=0 for out-of-range Ctrl.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.Ctrl == SEL_W'(k)) begin
        sel_data = bus.Entradas[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  // Two-entry FIFO: head drives the outputs, tail holds the second beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      head_data <= '0;
      head_err  <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= sel_data;
            head_err  <= ~sel_hit;
          end else begin
            tail_data <= sel_data;
            tail_err  <= ~sel_hit;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          // Tail is kept zero whenever unused, so shifting it into the head
          // also zeroes the outputs when the FIFO drains to empty.
          head_data <= tail_data;
          head_err  <= tail_err;
          tail_data <= '0;
          tail_err  <= 1'b0;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable with count==1: the new beat replaces the head.
          head_data <= sel_data;
          head_err  <= ~sel_hit;
        end
        default: ;
      endcase
    end
  end

`ifdef MUX_SEL_ERR_CNT_EN
  // Saturating count of captured out-of-range beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (push && !sel_hit && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
